zl_dvb_s_puncturer: RTL

ZL_DVB_S_PUNCTURER -- requirements
Module: zl_dvb_s_puncturer

---
 rtl/zl_dvb_s_pkg.sv | 38 +++
 rtl/zl_dvb_s_puncture_pattern.sv | 55 +++++
 rtl/zl_dvb_s_puncturer.sv | 88 ++++++++
 3 files changed

// File: rtl/zl_dvb_s_pkg.sv
// DVB-S puncturer shared definitions.
// Rate codes, period lengths and keep masks.
package zl_dvb_s_pkg;

  typedef enum logic [2:0] {
    RATE_1_2 = 3'd0,
    RATE_2_3 = 3'd1,
    RATE_3_4 = 3'd2,
    RATE_5_6 = 3'd3,
    RATE_7_8 = 3'd4
  } rate_e;

  localparam logic [2:0] P_1_2 = 3'd1;
  localparam logic [2:0] P_2_3 = 3'd2;
  localparam logic [2:0] P_3_4 = 3'd3;
  localparam logic [2:0] P_5_6 = 3'd5;
  localparam logic [2:0] P_7_8 = 3'd7;

  // Bit n of a mask is the keep flag for phase n.
  localparam logic [6:0] XM_1_2 = 7'b0000001;
  localparam logic [6:0] YM_1_2 = 7'b0000001;
  localparam logic [6:0] XM_2_3 = 7'b0000001;
  localparam logic [6:0] YM_2_3 = 7'b0000011;
  localparam logic [6:0] XM_3_4 = 7'b0000101;
  localparam logic [6:0] YM_3_4 = 7'b0000011;
  localparam logic [6:0] XM_5_6 = 7'b0010101;
  localparam logic [6:0] YM_5_6 = 7'b0001011;
  localparam logic [6:0] XM_7_8 = 7'b1010001;
  localparam logic [6:0] YM_7_8 = 7'b0101111;

  // Unused codes 5..7 fall back to rate 1/2.
  function automatic logic [2:0] norm_rate(
    input logic [2:0] r
  );
    return (r > 3'd4) ? 3'd0 : r;
  endfunction

endpackage

// File: rtl/zl_dvb_s_puncture_pattern.sv
// DVB-S puncture pattern lookup.
// Maps (rate, phase) to keep flags and period end.
module zl_dvb_s_puncture_pattern
  import zl_dvb_s_pkg::*;
(
  input  logic [2:0] rate_active,
  input  logic [2:0] phase,
  output logic       keep_x,
  output logic       keep_y,
  output logic       last_phase
);

  logic [7:0] w_xm;
  logic [7:0] w_ym;
  logic [2:0] w_per;

  // Select masks and period for the active rate.
  always_comb begin
    w_xm  = {1'b0, XM_1_2};
    w_ym  = {1'b0, YM_1_2};
    w_per = P_1_2;
    case (rate_active)
      RATE_2_3: begin
        w_xm  = {1'b0, XM_2_3};
        w_ym  = {1'b0, YM_2_3};
        w_per = P_2_3;
      end
      RATE_3_4: begin
        w_xm  = {1'b0, XM_3_4};
        w_ym  = {1'b0, YM_3_4};
        w_per = P_3_4;
      end
      RATE_5_6: begin
        w_xm  = {1'b0, XM_5_6};
        w_ym  = {1'b0, YM_5_6};
        w_per = P_5_6;
      end
      RATE_7_8: begin
        w_xm  = {1'b0, XM_7_8};
        w_ym  = {1'b0, YM_7_8};
        w_per = P_7_8;
      end
      default: begin
        w_xm  = {1'b0, XM_1_2};
        w_ym  = {1'b0, YM_1_2};
        w_per = P_1_2;
      end
    endcase
  end

  assign keep_x     = w_xm[phase];
  assign keep_y     = w_ym[phase];
  assign last_phase = (phase == w_per - 3'd1);

endmodule

// File: rtl/zl_dvb_s_puncturer.sv
// DVB-S convolutional code puncturer.
// Kept X/Y bits pass through a 3-bit FIFO into I/Q pairs.
module zl_dvb_s_puncturer
  import zl_dvb_s_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] rate,
  input  logic       data_in_x,
  input  logic       data_in_y,
  input  logic       data_in_req,
  output logic       data_in_ack,
  output logic       data_out_i,
  output logic       data_out_q,
  output logic       data_out_req,
  input  logic       data_out_ack,
  output logic [2:0] rate_active
);

  logic [2:0] r_fifo;
  logic [1:0] r_count;
  logic [2:0] r_phase;
  logic [2:0] r_rate;

  logic [2:0] w_rate_eff;
  logic       w_keep_x;
  logic       w_keep_y;
  logic       w_last;
  logic       w_push;
  logic       w_pop;
  logic [2:0] w_fifo_nx;
  logic [1:0] w_idx;

  // A new period takes the live rate; mid-period keeps the latched one.
  assign w_rate_eff = (r_phase == 3'd0) ?
                      norm_rate(rate) : r_rate;

  zl_dvb_s_puncture_pattern u_pat (
    .rate_active (w_rate_eff),
    .phase       (r_phase),
    .keep_x      (w_keep_x),
    .keep_y      (w_keep_y),
    .last_phase  (w_last)
  );

  assign data_out_req = !rst && (r_count >= 2'd2);
  assign data_out_i   = rst ? 1'b0 : r_fifo[0];
  assign data_out_q   = rst ? 1'b0 : r_fifo[1];
  assign rate_active  = rst ? 3'd0 : r_rate;
  assign data_in_ack  = rst || (r_count <= 2'd1) ||
                        data_out_ack;

  assign w_pop  = data_out_req && data_out_ack;
  assign w_push = data_in_req && data_in_ack;

  // Pop the head pair, then append kept bits X before Y.
  always_comb begin
    w_fifo_nx = w_pop ? {2'b00, r_fifo[2]} : r_fifo;
    w_idx     = w_pop ? r_count - 2'd2 : r_count;
    if (w_push && w_keep_x) begin
      w_fifo_nx[w_idx] = data_in_x;
      w_idx            = w_idx + 2'd1;
    end
    if (w_push && w_keep_y) begin
      w_fifo_nx[w_idx] = data_in_y;
      w_idx            = w_idx + 2'd1;
    end
  end

  // FIFO, phase counter and rate latch.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_fifo  <= '0;
      r_count <= '0;
      r_phase <= '0;
      r_rate  <= '0;
    end else begin
      r_fifo  <= w_fifo_nx;
      r_count <= w_idx;
      if (w_push) begin
        r_phase <= w_last ? 3'd0 : r_phase + 3'd1;
        if (r_phase == 3'd0)
          r_rate <= w_rate_eff;
      end
    end
  end

endmodule
